// File: rtl/clksel_ctrl_if.sv
// Request/status bundle between the register/SPI-side controller and clksel_ctrl.
// slave  : seen by clksel_ctrl (requests and PLL lock in, select/status out).
// master : seen by the requesting block.
// Signals:
//   i_req_valid / i_req_sel / o_req_ready : clock-select request handshake
//   i_pll_lock                            : raw PLL lock (asynchronous)
//   o_pll_en / o_sel                      : PLL enable and clock-switch select
//   o_busy / o_done / o_err               : status and completion/error pulses
interface clksel_ctrl_if;
    logic i_req_valid;
    logic i_req_sel;
    logic o_req_ready;
    logic i_pll_lock;
    logic o_pll_en;
    logic o_sel;
    logic o_busy;
    logic o_done;
    logic o_err;

    modport slave (
        input  i_req_valid, i_req_sel, i_pll_lock,
        output o_req_ready, o_pll_en, o_sel, o_busy, o_done, o_err
    );

    modport master (
        output i_req_valid, i_req_sel, i_pll_lock,
        input  o_req_ready, o_pll_en, o_sel, o_busy, o_done, o_err
    );
endinterface

// File: rtl/clksel_ctrl.sv
// Clock-select sequencer in front of the dynamic clock switch.
// Enables the clock-B PLL and waits for synchronised lock before raising o_sel,
// holds a settle dwell after every o_sel edge, and falls back to clock A on lock loss.
// Ports:
//   i_clk      : always-on oscillator clock
//   i_areset_n : asynchronous active-low reset
//   bus        : clksel_ctrl_if.slave (request handshake, PLL lock/enable, select, status)
module clksel_ctrl #(
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic         i_clk,
    input  logic         i_areset_n,
    clksel_ctrl_if.slave bus
);

    localparam int unsigned CNT_SPAN = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned CW       = $clog2(CNT_SPAN) + 1;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOCK,
        SETTLE_B,
        SETTLE_A,
        PLL_OFF
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   sel_q;
    logic                   pll_en_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Saturating increment: the counter never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_pll_lock};
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            pll_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_q && !lock_s) begin
                        // Lock loss while running on clock B: drop back to A.
                        sel_q   <= 1'b0;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE_A;
                    end else if (bus.i_req_valid) begin
                        if (bus.i_req_sel == sel_q) begin
                            done_q <= 1'b1;
                        end else if (bus.i_req_sel) begin
                            pll_en_q <= 1'b1;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= WAIT_LOCK;
                        end else begin
                            sel_q   <= 1'b0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= SETTLE_A;
                        end
                    end
                end
                WAIT_LOCK: begin
                    cnt_q <= cnt_d;
                    // Lock is tested first so it wins over a coincident timeout.
                    if (lock_s) begin
                        sel_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= SETTLE_B;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        pll_en_q <= 1'b0;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                SETTLE_B: begin
                    if (!lock_s) begin
                        sel_q   <= 1'b0;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= SETTLE_A;
                    end else if (cnt_q == SETTLE_LAST) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                SETTLE_A: begin
                    // PLL stays enabled until the switch has settled on clock A.
                    if (cnt_q == SETTLE_LAST) begin
                        pll_en_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= PLL_OFF;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                PLL_OFF: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    sel_q    <= 1'b0;
                    pll_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_sel       = sel_q;
    assign bus.o_pll_en    = pll_en_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_req_ready = ~busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Scoreboard bench for clksel_ctrl (LOCK_TIMEOUT=16, SETTLE_CYCLES=8, SYNC_STAGES=2).
// Output vector layout: {ready, busy, sel, pll_en, done, err}.
module tb_clksel_ctrl;

    localparam int unsigned LT = 16;
    localparam int unsigned SC = 8;
    localparam int unsigned SS = 2;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
        string      name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    exp_t sb[$];

    clksel_ctrl_if ifc ();

    clksel_ctrl #(
        .LOCK_TIMEOUT (LT),
        .SETTLE_CYCLES(SC),
        .SYNC_STAGES  (SS)
    ) dut (
        .i_clk     (clk),
        .i_areset_n(rst_n),
        .bus       (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] outs();
        return {ifc.o_req_ready, ifc.o_busy, ifc.o_sel, ifc.o_pll_en, ifc.o_done, ifc.o_err};
    endfunction

    function automatic void push(int c, logic [5:0] v, string n);
        exp_t e;
        e.cyc  = c;
        e.vec  = v;
        e.name = n;
        sb.push_back(e);
    endfunction

    // Called #1 after a posedge; accept happens on the next posedge, a = its cycle index.
    task automatic issue(input logic s, output int a);
        ifc.i_req_valid = 1'b1;
        ifc.i_req_sel   = s;
        @(posedge clk);
        #1;
        a = cyc;
        ifc.i_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every change of the output vector consumes one expected entry.
    initial begin
        logic [5:0] prev;
        logic [5:0] v;
        exp_t       e;
        prev = 6'b100000;
        wait (mon_en);
        forever begin
            @(negedge clk);
            v = outs();
            if (v !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%b", cyc, v);
                end else begin
                    e = sb.pop_front();
                    if (v !== e.vec || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL %s got cyc=%0d outs=%b exp cyc=%0d outs=%b",
                                 e.name, cyc, v, e.cyc, e.vec);
                    end
                end
                prev = v;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1);
    end

    initial begin
        int a;
        int l;
        ifc.i_req_valid = 1'b0;
        ifc.i_req_sel   = 1'b0;
        ifc.i_pll_lock  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (outs() !== 6'b100000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", outs(), 6'b100000);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Redundant request to clock A.
        issue(1'b0, a);
        push(a,     6'b100010, "redundant_done");
        push(a + 1, 6'b100000, "redundant_end");
        idle(4);

        // Lock timeout.
        issue(1'b1, a);
        push(a,      6'b010100, "tmo_pll_en");
        push(a + 16, 6'b100001, "tmo_err");
        push(a + 17, 6'b100000, "tmo_end");
        idle(20);

        // Switch to B, lock rises 5 cycles after accept.
        issue(1'b1, a);
        push(a,      6'b010100, "b_pll_en");
        push(a + 8,  6'b011100, "b_sel");
        push(a + 16, 6'b101110, "b_done");
        push(a + 17, 6'b101100, "b_end");
        idle(5);
        ifc.i_pll_lock = 1'b1;
        idle(14);

        // Return to A.
        issue(1'b0, a);
        push(a,     6'b010100, "a_sel_low");
        push(a + 8, 6'b010010, "a_pll_off_done");
        push(a + 9, 6'b100000, "a_end");
        idle(12);

        // Switch to B with lock already present.
        issue(1'b1, a);
        push(a,      6'b010100, "b2_pll_en");
        push(a + 1,  6'b011100, "b2_sel");
        push(a + 9,  6'b101110, "b2_done");
        push(a + 10, 6'b101100, "b2_end");
        idle(12);

        // Lock loss while idle on clock B.
        l = cyc;
        ifc.i_pll_lock = 1'b0;
        push(l + 3,  6'b010101, "idle_loss_err");
        push(l + 4,  6'b010100, "idle_loss_settle");
        push(l + 11, 6'b010010, "idle_loss_done");
        push(l + 12, 6'b100000, "idle_loss_end");
        idle(15);

        // Lock loss during SETTLE_B.
        ifc.i_pll_lock = 1'b1;
        idle(4);
        issue(1'b1, a);
        push(a,      6'b010100, "sb_loss_pll_en");
        push(a + 1,  6'b011100, "sb_loss_sel");
        idle(3);
        ifc.i_pll_lock = 1'b0;
        push(a + 6,  6'b010101, "sb_loss_err");
        push(a + 7,  6'b010100, "sb_loss_settle");
        push(a + 14, 6'b010010, "sb_loss_done");
        push(a + 15, 6'b100000, "sb_loss_end");
        idle(14);

        // Asynchronous reset in SETTLE_B.
        ifc.i_pll_lock = 1'b1;
        idle(4);
        issue(1'b1, a);
        push(a,     6'b010100, "rst_pll_en");
        push(a + 1, 6'b011100, "rst_sel");
        idle(3);
        rst_n = 1'b0;
        push(a + 3, 6'b100000, "rst_outs");
        #1;
        checks++;
        if (outs() !== 6'b100000) begin
            failures++;
            $display("FAIL rst_async got=%b exp=%b", outs(), 6'b100000);
        end
        idle(3);
        rst_n = 1'b1;
        idle(3);
        issue(1'b0, a);
        push(a,     6'b100010, "post_rst_done");
        push(a + 1, 6'b100000, "post_rst_end");
        idle(4);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_events got=%0d pending exp=0 next=%s", sb.size(), sb[0].name);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
